// File: rtl/f512x8_drain_ctrl.sv
// rtl/f512x8_drain_ctrl.sv - pop-side drain controller for the 512x8 usb2serial FIFO
module f512x8_drain_ctrl #(
    parameter int BURST_LEN  = 16,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Enable,
    input  logic                 Flush_Req,
    input  logic [3:0]           Pop_Flag,
    input  logic [7:0]           Fifo_Dout,
    output logic                 Fifo_Pop,
    output logic                 Fifo_Pop_Flush,
    output logic [7:0]           Tx_Data,
    output logic                 Tx_Valid,
    input  logic                 Tx_Ready,
    output logic [CNT_WIDTH-1:0] Byte_Count,
    output logic                 Busy
);

    // Burst counter runs 0..BURST_LEN-1 and clears on the last byte of a burst;
    // gap counter runs 0..GAP_CYCLES-1 while in GAP.
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_CAPT,
        S_HOLD,
        S_GAP,
        S_FLUSH
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic [CNT_WIDTH-1:0]   byte_count;
    logic [BW-1:0]          burst_cnt;
    logic [GW-1:0]          gap_cnt;
    logic                   pend_flush;
    logic                   handshake;
    logic                   burst_done;

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; Pop_Flag is only looked at in IDLE, which is always
    // at least two cycles after the previous pop, covering the FIFO flag lag.
    always_comb begin
        state_nxt  = state;
        handshake  = (state == S_HOLD) && tx_valid && Tx_Ready;
        burst_done = handshake && (burst_cnt == BURST_LAST);
        case (state)
            S_IDLE: begin
                if (Flush_Req) begin
                    state_nxt = S_FLUSH;
                end else if (Enable && (Pop_Flag != 4'h0)) begin
                    state_nxt = S_POP;
                end
            end
            S_POP: begin
                state_nxt = S_CAPT;
            end
            S_CAPT: begin
                if (pend_flush || Flush_Req) begin
                    state_nxt = S_FLUSH;
                end else begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (Flush_Req) begin
                    state_nxt = S_FLUSH;
                end else if (handshake) begin
                    if (burst_done && (GAP_CYCLES > 0)) begin
                        state_nxt = S_GAP;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (Flush_Req) begin
                    state_nxt = S_FLUSH;
                end else if (gap_cnt == GAP_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: output byte register, counters and the deferred-flush flag
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            byte_count <= '0;
            burst_cnt  <= '0;
            gap_cnt    <= '0;
            pend_flush <= 1'b0;
        end else begin
            case (state)
                S_POP: begin
                    if (Flush_Req) begin
                        pend_flush <= 1'b1;
                    end
                end
                S_CAPT: begin
                    if (!(pend_flush || Flush_Req)) begin
                        tx_data  <= Fifo_Dout;
                        tx_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (handshake) begin
                        tx_valid   <= 1'b0;
                        byte_count <= byte_count + 1'b1;
                        burst_cnt  <= burst_done ? '0 : burst_cnt + 1'b1;
                    end else if (Flush_Req) begin
                        tx_valid <= 1'b0;
                    end
                end
                S_GAP: begin
                    gap_cnt <= (state_nxt == S_GAP) ? gap_cnt + 1'b1 : '0;
                end
                S_FLUSH: begin
                    burst_cnt  <= '0;
                    pend_flush <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign Fifo_Pop       = (state == S_POP);
    assign Fifo_Pop_Flush = (state == S_FLUSH);
    assign Tx_Data        = tx_data;
    assign Tx_Valid       = tx_valid;
    assign Byte_Count     = byte_count;
    assign Busy           = (state != S_IDLE);

endmodule

// File: tb/tb_f512x8_drain_ctrl.sv
// tb/tb_f512x8_drain_ctrl.sv - directed scoreboard bench for f512x8_drain_ctrl
module tb_f512x8_drain_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Enable = 1'b0;
    logic       Flush_Req = 1'b0;
    logic [3:0] Pop_Flag = 4'h0;
    logic [7:0] Fifo_Dout = 8'h00;
    logic       Fifo_Pop;
    logic       Fifo_Pop_Flush;
    logic [7:0] Tx_Data;
    logic       Tx_Valid;
    logic       Tx_Ready = 1'b0;
    logic [3:0] Byte_Count;
    logic       Busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int pop_total = 0;
    int flush_total = 0;
    int pop_cyc[$];
    int hs_cyc[$];
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    f512x8_drain_ctrl #(
        .BURST_LEN(4),
        .GAP_CYCLES(3),
        .CNT_WIDTH(4)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .Enable(Enable),
        .Flush_Req(Flush_Req),
        .Pop_Flag(Pop_Flag),
        .Fifo_Dout(Fifo_Dout),
        .Fifo_Pop(Fifo_Pop),
        .Fifo_Pop_Flush(Fifo_Pop_Flush),
        .Tx_Data(Tx_Data),
        .Tx_Valid(Tx_Valid),
        .Tx_Ready(Tx_Ready),
        .Byte_Count(Byte_Count),
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    // FIFO model: synchronous read, data valid the cycle after POP
    always @(posedge Clk) begin
        if (Fifo_Pop && fifo_q.size() > 0) Fifo_Dout <= fifo_q.pop_front();
        if (Fifo_Pop_Flush) fifo_q.delete();
    end

    always @(negedge Clk) Pop_Flag <= (fifo_q.size() > 15) ? 4'hF : 4'(fifo_q.size());

    // Monitor: scoreboard compare on handshake, event logging
    always @(negedge Clk) begin
        chk("pop_flush_excl", {31'd0, Fifo_Pop & Fifo_Pop_Flush}, 32'd0);
        if (Fifo_Pop) begin
            chk("pop_on_empty", {31'd0, fifo_q.size() != 0}, 32'd1);
            pop_total++;
            pop_cyc.push_back(cyc);
        end
        if (Fifo_Pop_Flush) flush_total++;
        if (Tx_Valid && Tx_Ready && Rst_n) begin
            hs_cnt++;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("hs_unexpected", {24'd0, Tx_Data}, 32'hFFFF_FFFF);
            else chk("tx_data", {24'd0, Tx_Data}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic load_drop(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_cnt < target && n < 300) begin
            tick(1);
            n++;
        end
        chk("hs_timeout", {31'd0, hs_cnt >= target}, 32'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!Tx_Valid && n < 50) begin
            tick(1);
            n++;
        end
        chk("valid_timeout", {31'd0, Tx_Valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int f0;
        // Reset values
        tick(2);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_valid", {31'd0, Tx_Valid}, 32'd0);
        chk("rst_pop", {31'd0, Fifo_Pop}, 32'd0);
        chk("rst_flush", {31'd0, Fifo_Pop_Flush}, 32'd0);
        chk("rst_count", {28'd0, Byte_Count}, 32'd0);
        Rst_n = 1'b1;
        tick(2);

        // Streaming three bytes
        Enable = 1'b1;
        Tx_Ready = 1'b1;
        load(8'hA1);
        load(8'hB2);
        load(8'hC3);
        wait_hs(3);
        tick(10);
        chk("stream_count", {28'd0, Byte_Count}, 32'd3);
        chk("stream_pops", pop_total, 32'd3);
        chk("stream_space1", pop_cyc[1] - pop_cyc[0], 32'd4);
        chk("stream_space2", pop_cyc[2] - pop_cyc[1], 32'd4);

        // Backpressure
        Tx_Ready = 1'b0;
        load(8'h5A);
        wait_valid();
        p0 = pop_total;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("bp_data", {24'd0, Tx_Data}, 32'h5A);
            chk("bp_valid", {31'd0, Tx_Valid}, 32'd1);
        end
        chk("bp_no_pop", pop_total - p0, 32'd0);
        Tx_Ready = 1'b1;
        wait_hs(4);
        tick(1);
        chk("bp_count", {28'd0, Byte_Count}, 32'd4);

        // Burst pacing: 8 bytes, burst 4, gap 3
        tick(10);
        pop_cyc.delete();
        hs_cyc.delete();
        for (int i = 0; i < 8; i++) load(8'h10 + 8'(i));
        wait_hs(12);
        tick(10);
        chk("burst_gap", pop_cyc[4] - hs_cyc[3], 32'd5);
        chk("burst_nogap", pop_cyc[1] - hs_cyc[0], 32'd2);
        chk("burst_count", {28'd0, Byte_Count}, 32'd12);

        // Flush while holding
        Tx_Ready = 1'b0;
        load_drop(8'h77);
        wait_valid();
        f0 = flush_total;
        Flush_Req = 1'b1;
        tick(1);
        chk("fh_pulse", {31'd0, Fifo_Pop_Flush}, 32'd1);
        chk("fh_valid", {31'd0, Tx_Valid}, 32'd0);
        Flush_Req = 1'b0;
        tick(3);
        chk("fh_one_pulse", flush_total - f0, 32'd1);
        chk("fh_count", {28'd0, Byte_Count}, 32'd12);

        // Flush while popping
        Tx_Ready = 1'b1;
        load_drop(8'h99);
        begin
            int n = 0;
            while (!Fifo_Pop && n < 50) begin
                tick(1);
                n++;
            end
            chk("fp_pop_timeout", {31'd0, Fifo_Pop}, 32'd1);
        end
        Flush_Req = 1'b1;
        tick(1);
        Flush_Req = 1'b0;
        chk("fp_capt_valid", {31'd0, Tx_Valid}, 32'd0);
        tick(1);
        chk("fp_pulse", {31'd0, Fifo_Pop_Flush}, 32'd1);
        chk("fp_valid", {31'd0, Tx_Valid}, 32'd0);
        tick(5);
        chk("fp_no_hs", hs_cnt, 32'd12);
        chk("fp_count", {28'd0, Byte_Count}, 32'd12);

        // Counter wrap: 17 bytes total
        for (int i = 0; i < 5; i++) load(8'h30 + 8'(i));
        wait_hs(17);
        tick(1);
        chk("wrap_count", {28'd0, Byte_Count}, 32'd1);

        // Enable dropped during HOLD
        tick(10);
        Tx_Ready = 1'b0;
        p0 = pop_total;
        load(8'hE1);
        load(8'hE2);
        wait_valid();
        Enable = 1'b0;
        Tx_Ready = 1'b1;
        wait_hs(18);
        tick(15);
        chk("en_pops", pop_total - p0, 32'd1);
        chk("en_hs", hs_cnt, 32'd18);
        Enable = 1'b1;
        wait_hs(19);
        tick(1);
        chk("en_count", {28'd0, Byte_Count}, 32'd3);

        // Asynchronous reset mid-HOLD
        tick(10);
        Tx_Ready = 1'b0;
        load_drop(8'h42);
        wait_valid();
        #2;
        Rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, Tx_Valid}, 32'd0);
        chk("ar_busy", {31'd0, Busy}, 32'd0);
        chk("ar_count", {28'd0, Byte_Count}, 32'd0);
        chk("ar_data", {24'd0, Tx_Data}, 32'd0);
        chk("ar_pop", {31'd0, Fifo_Pop | Fifo_Pop_Flush}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
